nibble_adder_scheduler: RTL and testbench
=========================================

Name: nibble_adder_scheduler

Overview:
Shares one four_bit_adder instance between two requesters, adding WIDTH-bit operands one nibble per cycle with carry chained through a register. A round-robin arbiter picks the requester, and an FSM sequences the nibbles. The block returns the sum, carry-out and winning requester ID over a valid/ready response channel. It sits between client logic and the single physical adder so that wide additions reuse the existing 4-bit datapath.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4; NIBBLES = WIDTH/4 is a derived localparam

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req0_valid  input  1  requester 0 has operands
req0_ready  output  1  requester 0 operands accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_cin  input  1  requester 0 carry-in
req1_valid  input  1  requester 1 has operands
req1_ready  output  1  requester 1 operands accepted this cycle
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
req1_cin  input  1  requester 1 carry-in
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_sum  output  WIDTH  A+B+cin modulo 2^WIDTH
resp_cout  output  1  carry out of MSB nibble
resp_id  output  1  requester that owns the result

Behaviour:
- Reset is asynchronous and active-high. While rst is high and immediately on its assertion:
  - FSM goes to IDLE.
  - resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0.
  - Nibble index = 0, carry register = 0.
  - last_grant=1, so req0 wins the first tie.
- States: IDLE, RUN, DONE.
- IDLE:
  - reqN_ready is combinational. It is high only for the requester granted this cycle, and never for both.
  - Grant rule: if only one valid is high, grant it. If both are high, grant the requester != last_grant.
  - On a valid&&ready edge: capture a, b and cin into internal registers, set resp_id = grant, set last_grant = grant, nibble index = 0, then go to RUN.
  - No valid: stay in IDLE.
- RUN:
  - Each cycle the shared adder sees nibble k of captured A and B, with cin = carry register (captured cin at k=0).
  - At each edge, nibble k of the sum register takes the adder sum, carry register takes the adder cout, and k increments.
  - After the edge that processes nibble NIBBLES-1, go to DONE.
  - Exactly NIBBLES cycles in RUN. Both ready outputs are 0.
- DONE:
  - resp_valid=1. resp_sum, resp_cout and resp_id are held stable until the resp_valid&&resp_ready edge, then go to IDLE.
  - resp_valid drops in the cycle after the handshake. Both ready outputs are 0.
  - A new request can be accepted at the earliest one cycle after the response handshake, in IDLE. Back-to-back throughput is one result per NIBBLES+2 cycles.
- Latency: resp_valid rises NIBBLES rising edges after the accept edge (4 for WIDTH=16).
- Operand inputs may change freely after acceptance; only captured values are used.
- resp_sum and resp_cout are only meaningful while resp_valid=1. Between transactions they hold the last result.
- Arithmetic: the result is a plain WIDTH-bit add with no saturation. Overflow wraps, and the carry is reported only on resp_cout.
- Reset mid-RUN or mid-DONE: the transaction is aborted and the result discarded; no response is produced. The requester must re-issue.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- A requester dropping valid before it is granted is legal; no state is affected.

Test Plan:
1. After reset, req0 a=0x0001 b=0x0002 cin=0, resp_ready=1 → req0_ready=1 for one cycle. resp_valid rises 4 edges later with sum=0x0003, cout=0, id=0, then returns to IDLE.
2. req1 a=0xFFFF b=0x0001 cin=0 → sum=0x0000, cout=1, id=1, confirming carry rippling through all 4 nibbles. Also req0 a=0x0F0F b=0x00F1 cin=1 → sum=0x1001, cout=0.
3. After reset, both valid in the same cycle with req0 a=0x0505 b=0x0606 cin=1 → req0 granted first (sum=0x0B0C, id=0). req1 is granted next, and a third simultaneous request goes to req0 again (alternation).
4. Backpressure: resp_ready held 0 for 5 cycles in DONE → resp_valid stays 1 and sum/cout/id stay stable. req0_ready and req1_ready stay 0 throughout even with both valid. Handshake on cycle 6, then resp_valid=0 the next cycle.
5. Assert rst for 1 cycle during RUN (after nibble 1) → all outputs 0 immediately, no response emitted. A following req0 0x1234+0x1111 cin=0 yields sum=0x2345, cout=0.
6. Change req0_a/b on the cycle after acceptance (e.g. 0x0001+0x0002 captured, inputs switched to 0xFFFF) → result is still 0x0003.

Source files
------------

// File: rtl/nibble_adder_scheduler.sv
// Round-robin shared 4-bit adder: two requesters, WIDTH-bit add one nibble per cycle,
// carry chained through a register, result returned over a valid/ready channel.
module nibble_adder_scheduler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_id
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;
  logic             last_grant;

  logic             any_valid_c, grant_c, accept_c;
  logic [3:0]       nib_a_c, nib_b_c, add_sum_c;
  logic             add_cout_c;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    any_valid_c = req0_valid | req1_valid;
    grant_c     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  assign req0_ready = (state == IDLE) && any_valid_c && !grant_c;
  assign req1_ready = (state == IDLE) && any_valid_c &&  grant_c;
  assign accept_c   = req0_ready | req1_ready;

  // The single shared 4-bit adder, fed nibble k of the captured operands.
  always_comb begin
    nib_a_c = 4'(a_q >> {k_q, 2'b00});
    nib_b_c = 4'(b_q >> {k_q, 2'b00});
    {add_cout_c, add_sum_c} = 5'(nib_a_c) + 5'(nib_b_c) + 5'(carry_q);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c)       state_nxt = RUN;
      RUN:     if (k_q == K_LAST)  state_nxt = DONE;
      DONE:    if (resp_ready)     state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, nibble sequencing and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      k_q        <= '0;
      last_grant <= 1'b1;
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      resp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            a_q        <= grant_c ? req1_a   : req0_a;
            b_q        <= grant_c ? req1_b   : req0_b;
            carry_q    <= grant_c ? req1_cin : req0_cin;
            resp_id    <= grant_c;
            last_grant <= grant_c;
            k_q        <= '0;
          end
        end
        RUN: begin
          resp_sum[{k_q, 2'b00} +: 4] <= add_sum_c;
          carry_q   <= add_cout_c;
          resp_cout <= add_cout_c;
          k_q       <= k_q + 1'b1;
          if (k_q == K_LAST) resp_valid <= 1'b1;
        end
        DONE: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_adder_scheduler.sv
// Randomized self-checking bench for nibble_adder_scheduler against an arithmetic
// reference (A+B+cin) and a round-robin grant model.
module tb_nibble_adder_scheduler;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_cin, req1_valid, req1_cin;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             resp_valid, resp_ready, resp_cout, resp_id;
  logic [WIDTH-1:0] resp_sum;

  int n_checks = 0;
  int n_fail   = 0;
  logic lg_m;   // model of who was served last

  nibble_adder_scheduler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in IDLE, positioned just after a rising edge.
  task automatic txn(input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0, input logic c0,
                     input logic v1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input logic c1,
                     input int stall, input bit hold);
    logic             g;
    logic [WIDTH:0]   exp;
    int               n;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    resp_ready = 1'b0;
    #1;
    g   = (v0 && v1) ? ~lg_m : v1;
    exp = g ? ({1'b0, a1} + {1'b0, b1} + (WIDTH+1)'(c1))
            : ({1'b0, a0} + {1'b0, b0} + (WIDTH+1)'(c0));
    check("ready0_idle", 32'(req0_ready), 32'(!g));
    check("ready1_idle", 32'(req1_ready), 32'(g));
    step();
    lg_m = g;
    // operands are scrambled right after acceptance; only captured values may matter
    req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_cin = 1'($urandom);
    req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_cin = 1'($urandom);
    if (!hold) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      #1;
      check("ready_busy", 32'({req0_ready, req1_ready}), 32'(0));
      step();
      n++;
    end
    check("latency", 32'(n), 32'(NIBBLES));
    check("sum", 32'(resp_sum), 32'(exp[WIDTH-1:0]));
    check("cout", 32'(resp_cout), 32'(exp[WIDTH]));
    check("id", 32'(resp_id), 32'(g));
    for (int s = 0; s < stall; s++) begin
      step();
      check("bp_valid", 32'(resp_valid), 32'(1));
      check("bp_sum", 32'(resp_sum), 32'(exp[WIDTH-1:0]));
      check("bp_cout", 32'(resp_cout), 32'(exp[WIDTH]));
      check("bp_id", 32'(resp_id), 32'(g));
      check("bp_ready", 32'({req0_ready, req1_ready}), 32'(0));
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("valid_drop", 32'(resp_valid), 32'(0));
  endtask

  initial begin
    logic v0, v1;
    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    lg_m = 1'b1;
    #3;
    check("rst_valid", 32'(resp_valid), 32'(0));
    check("rst_sum", 32'(resp_sum), 32'(0));
    check("rst_cout", 32'(resp_cout), 32'(0));
    check("rst_id", 32'(resp_id), 32'(0));
    step();
    rst = 1'b0;
    step();
    check("idle_noreq", 32'({req0_ready, req1_ready}), 32'(0));

    // directed cases
    txn(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, '0, '0, 1'b0, 0, 1'b0);
    txn(1'b0, '0, '0, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    txn(1'b1, 16'h0F0F, 16'h00F1, 1'b1, 1'b0, '0, '0, 1'b0, 0, 1'b0);

    // fairness after a fresh reset: 0,1,0 with both always valid
    rst = 1'b1; step(); rst = 1'b0; lg_m = 1'b1; step();
    txn(1'b1, 16'h0505, 16'h0606, 1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 0, 1'b1);
    txn(1'b1, 16'h0505, 16'h0606, 1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 0, 1'b1);
    txn(1'b1, 16'hABCD, 16'h1234, 1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 0, 1'b1);

    // backpressure with both requesters pushing
    txn(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b1, 5, 1'b1);

    // reset in the middle of RUN aborts the transaction
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 1'b0;
    step();
    req0_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(resp_valid), 32'(0));
    check("abort_sum", 32'(resp_sum), 32'(0));
    check("abort_cout", 32'(resp_cout), 32'(0));
    check("abort_id", 32'(resp_id), 32'(0));
    step();
    rst = 1'b0; lg_m = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_noresp", 32'(resp_valid), 32'(0));
    end
    txn(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, '0, '0, 1'b0, 0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      txn(v0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
          v1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        step();
        check("idle_gap", 32'({req0_ready, req1_ready, resp_valid}), 32'(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
